// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: frame sequencer that walks (x, y) in raster order,
// column fastest, and emits one coordinate beat per valid/ready transfer.
// Each beat carries SOL/EOL/SOF/EOF markers, and done_o pulses once after
// the EOF beat transfers.
// Optional feature macro: RASTER_SCAN_HBLANK_EN. When it is defined, HBlank
// idle cycles are inserted after every non-final line.
module raster_scan_ctrl #(
  parameter int Width  = 10,
  parameter int HBlank = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [Width-1:0] max_x_i,
  input  logic [Width-1:0] max_y_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] x_o,
  output logic [Width-1:0] y_o,
  output logic             sol_o,
  output logic             eol_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic             done_o
);

  // Reject configurations that cannot describe a frame.
  if (Width < 1 || HBlank < 0) begin : g_param_check
    $error("raster_scan_ctrl: Width must be >= 1 and HBlank >= 0");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
`ifdef RASTER_SCAN_HBLANK_EN
    HBLANK = 2'd3,
`endif
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] x_q, x_d;
  logic [Width-1:0] y_q, y_d;
  logic [Width-1:0] mx_q, mx_d;
  logic [Width-1:0] my_q, my_d;

`ifdef RASTER_SCAN_HBLANK_EN
  // The counter runs from 0 to HBlank-1, so it needs width only for HBlank-1.
  localparam int BlankW = (HBlank > 1) ? $clog2(HBlank) : 1;
  localparam logic [BlankW-1:0] BlankLast = BlankW'((HBlank > 0) ? (HBlank - 1) : 0);
  logic [BlankW-1:0] blank_q, blank_d;
`endif

  // Next-state, coordinate and latched-maximum logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mx_d    = mx_q;
    my_d    = my_q;
`ifdef RASTER_SCAN_HBLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        // Start wins over a coincident abort; abort has no meaning here.
        if (start_i) begin
          state_d = SCAN;
          mx_d    = max_x_i;
          my_d    = max_y_i;
          x_d     = '0;
          y_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Abort drops the presented beat, so it is not counted as consumed.
        if (abort_i) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (ready_i) begin
          // Compare against the latched maximum so an all-ones max_x never overflows.
          if (x_q < mx_q) begin
            x_d = x_q + Width'(1);
          end else begin
            x_d = '0;
            if (y_q < my_q) begin
`ifdef RASTER_SCAN_HBLANK_EN
              if (HBlank > 0) begin
                state_d = HBLANK;
                blank_d = '0;
              end else begin
                y_d = y_q + Width'(1);
              end
`else
              y_d = y_q + Width'(1);
`endif
            end else begin
              state_d = DONE;
            end
          end
        end else begin
          state_d = SCAN;
        end
      end
`ifdef RASTER_SCAN_HBLANK_EN
      HBLANK: begin
        // y keeps the finished line's index until blanking ends.
        if (abort_i) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
          blank_d = '0;
        end else if (blank_q == BlankLast) begin
          state_d = SCAN;
          y_d     = y_q + Width'(1);
          blank_d = '0;
        end else begin
          blank_d = blank_q + BlankW'(1);
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mx_q    <= '0;
      my_q    <= '0;
`ifdef RASTER_SCAN_HBLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
`ifdef RASTER_SCAN_HBLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  // Handshake and status flags are decoded from the state register only.
  assign valid_o = (state_q == SCAN);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign x_o     = x_q;
  assign y_o     = y_q;

  // Markers are gated by valid_o so they are never high between beats.
  assign sol_o = valid_o & (x_q == '0);
  assign eol_o = valid_o & (x_q == mx_q);
  assign sof_o = sol_o & (y_q == '0);
  assign eof_o = eol_o & (y_q == my_q);

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Scoreboard bench for raster_scan_ctrl. Stimulus tasks push the expected
// beats into a queue. A negedge monitor pops an entry on every transfer,
// checks that outputs hold during stalls, and checks the blanking gaps.
module tb_raster_scan_ctrl;
  localparam int W   = 10;
  localparam int HBL = 4;
`ifdef RASTER_SCAN_HBLANK_EN
  localparam int GAP = HBL;
`else
  localparam int GAP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [W-1:0] max_x_i = '0;
  logic [W-1:0] max_y_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic [W-1:0] x_o;
  logic [W-1:0] y_o;
  logic         sol_o, eol_o, sof_o, eof_o, busy_o, done_o;

  typedef struct {
    int x;
    int y;
    bit sol;
    bit eol;
    bit sof;
    bit eof;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    beat_cnt = 0;
  int    ready_mode = 0;

  raster_scan_ctrl #(.Width(W), .HBlank(HBL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .max_x_i(max_x_i), .max_y_i(max_y_i), .valid_o(valid_o), .ready_i(ready_i),
    .x_o(x_o), .y_o(y_o), .sol_o(sol_o), .eol_o(eol_o), .sof_o(sof_o),
    .eof_o(eof_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic int pack(input int x, input int y, input bit s, input bit e,
                              input bit f, input bit l);
    return (x << 14) | (y << 4) | (int'(s) << 3) | (int'(e) << 2) | (int'(f) << 1) | int'(l);
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Ready driver: held high, or pseudo-random per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_i = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pops, stall stability, blanking gap lengths.
  initial begin
    int gap = 0;
    bit pstall = 0;
    int pval = 0;
    int act;
    beat_t e;
    forever begin
      @(negedge clk);
      act = pack(int'(x_o), int'(y_o), sol_o, eol_o, sof_o, eof_o);
      if (!rst_ni || !busy_o) begin
        gap = 0;
        pstall = 0;
      end else begin
        if (!valid_o && !done_o) gap++;
        if (pstall && valid_o) check(act == pval, "stall_hold", act, pval);
        if (done_o) check(gap == 0, "tail_gap", gap, 0);
        pstall = 0;
        if (valid_o && !abort_i) begin
          if (ready_i) begin
            if (q.size() == 0) begin
              check(1'b0, "extra_beat", act, 0);
            end else begin
              e = q.pop_front();
              check(act == pack(e.x, e.y, e.sol, e.eol, e.sof, e.eof), "beat", act,
                    pack(e.x, e.y, e.sol, e.eol, e.sof, e.eof));
              if (e.sol && !e.sof) check(gap == GAP, "line_gap", gap, GAP);
            end
            gap = 0;
            beat_cnt++;
          end else begin
            pstall = 1;
            pval = act;
          end
        end
      end
    end
  end

  task automatic push_beats(input int mx, input int my, input int limit);
    int n = 0;
    beat_t b;
    for (int y = 0; y <= my; y++) begin
      for (int x = 0; x <= mx; x++) begin
        if (n < limit) begin
          b.x = x; b.y = y;
          b.sol = (x == 0); b.eol = (x == mx);
          b.sof = (x == 0) && (y == 0); b.eof = (x == mx) && (y == my);
          q.push_back(b);
        end
        n++;
      end
    end
  endtask

  task automatic run_frame(input int mx, input int my, input bit poke, input bit abort_too);
    int budget;
    bit seen = 0;
    push_beats(mx, my, 1 << 30);
    budget = 4 * (mx + 1) * (my + 1) + GAP * (my + 1) + 40;
    @(posedge clk); #1;
    start_i = 1'b1; abort_i = abort_too;
    max_x_i = W'(mx); max_y_i = W'(my);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      start_i = poke && (i >= 2) && (i <= 5);
      abort_i = 1'b0;
      max_x_i = W'(7); max_y_i = W'(5);
      if (done_o) begin
        seen = 1;
        break;
      end
    end
    start_i = 1'b0;
    check(seen, "done_seen", int'(seen), 1);
    check(q.size() == 0, "beats_left", q.size(), 0);
    q.delete();
    @(posedge clk); #1;
    check(!done_o && !busy_o, "after_done", int'({done_o, busy_o}), 0);
  endtask

  // Waits (bounded) until `target` beats have transferred.
  task automatic wait_beats(input int target, input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (beat_cnt == target) begin
        ok = 1;
        break;
      end
    end
    check(ok, name, beat_cnt, target);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check({valid_o, busy_o, done_o, sol_o, eol_o, sof_o, eof_o} == 7'd0, "reset_flags",
          int'({valid_o, busy_o, done_o, sol_o, eol_o, sof_o, eof_o}), 0);
    check(x_o == '0 && y_o == '0, "reset_xy", int'(x_o) + int'(y_o), 0);
    rst_ni = 1'b1;

    run_frame(3, 2, 1'b0, 1'b0);        // 4x3 frame, ready held high
    ready_mode = 1;
    run_frame(3, 2, 1'b1, 1'b0);        // stalls, plus start pulses while busy
    ready_mode = 0;
    run_frame(0, 0, 1'b0, 1'b1);        // single beat; start+abort together in IDLE
    run_frame(15, 1, 1'b0, 1'b0);       // x wraps 15 -> 0 once
    run_frame(1023, 0, 1'b0, 1'b0);     // all-ones max_x, no overflow

    // Abort while beat 5 of a 4x3 frame is presented.
    base = beat_cnt;
    push_beats(3, 2, 5);
    @(posedge clk); #1;
    start_i = 1'b1; max_x_i = W'(3); max_y_i = W'(2);
    wait_beats(base + 5, "abort_wait");
    check(valid_o && x_o == W'(1) && y_o == W'(1), "abort_beat",
          pack(int'(x_o), int'(y_o), 1'b0, 1'b0, 1'b0, 1'b0), pack(1, 1, 1'b0, 1'b0, 1'b0, 1'b0));
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check({valid_o, busy_o} == 2'b00 && x_o == '0 && y_o == '0, "abort_idle",
          int'({valid_o, busy_o}) + int'(x_o) + int'(y_o), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check(!done_o && !busy_o, "abort_no_done", int'({done_o, busy_o}), 0);
    end
    check(beat_cnt == base + 5 && q.size() == 0, "abort_count", beat_cnt - base, 5);
    q.delete();
    run_frame(3, 2, 1'b0, 1'b0);

    // Mid-frame reset after the first line of a 3x2 frame.
    base = beat_cnt;
    push_beats(2, 1, 1 << 30);
    @(posedge clk); #1;
    start_i = 1'b1; max_x_i = W'(2); max_y_i = W'(1);
    wait_beats(base + 3, "reset_wait");
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check({valid_o, busy_o, done_o} == 3'b000 && x_o == '0 && y_o == '0, "midframe_reset",
          int'({valid_o, busy_o, done_o}) + int'(x_o) + int'(y_o), 0);
    rst_ni = 1'b1;
    q.delete();

    ready_mode = 1;
    run_frame(2, 1, 1'b0, 1'b0);
    ready_mode = 0;
    run_frame(2, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
